branch_target_predictor: RTL

- Parametrised branch prediction unit for the pipelined MIPS CPU. It lets IF redirect fetch speculatively instead of always fetching pc+4 and flushing on every taken branch resolved in EX.
- Direct-mapped branch target buffer with per-entry saturating direction counters.
- Combinational lookup from IF; registered update and statistics from EX resolution.
- Adds a table clear and a kernel-space prediction mode.

---
 rtl/branch_target_predictor.sv | 97 +++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational from IF; update and statistics are registered from EX.
module branch_target_predictor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INDEX_BITS     = 6,
  parameter int CTR_WIDTH      = 2,
  parameter int KERNEL_PREDICT = 0,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_WEAK = CTR_WIDTH'(1 << (CTR_WIDTH - 1));
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

  logic [ENTRIES-1:0]    valid;
  logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_mem [ENTRIES];
  logic [CTR_WIDTH-1:0]  ctr_mem    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  kernel_ok, upd_hit, upd_write;
  logic [CTR_WIDTH-1:0]  upd_ctr;
  logic                  unused_pc_bits;

  assign lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_idx = upd_pc[INDEX_BITS+1:2];
  assign up_tag = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign unused_pc_bits = ^upd_pc[1:0];

  // Supervisor code (top PC bit set) is never redirected unless enabled.
  assign kernel_ok   = (KERNEL_PREDICT != 0) || !lookup_pc[ADDR_WIDTH-1];
  assign pred_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag) && kernel_ok;
  assign pred_taken  = pred_hit && ctr_mem[lk_idx][CTR_WIDTH-1];
  assign pred_target = pred_taken ? target_mem[lk_idx] : lookup_pc + ADDR_WIDTH'(4);

  assign upd_hit   = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign upd_write = reset && !clear && upd_valid;

  always_comb begin
    // NOTE: default assignment first so every path drives upd_ctr and no latch is inferred.
    upd_ctr = ctr_mem[up_idx];
    if (!upd_hit) begin
      upd_ctr = CTR_WEAK;
    end else if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr = upd_ctr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      valid <= '0;
    end else if (upd_valid && (upd_hit || upd_taken)) begin
      valid[up_idx] <= 1'b1;
    end
  end

  // NOTE: the payload arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (upd_write && (upd_hit || upd_taken)) begin
      ctr_mem[up_idx] <= upd_ctr;
      tag_mem[up_idx] <= up_tag;
      if (upd_taken) target_mem[up_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (!clear && upd_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (upd_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule
